// File: rtl/rle_operand_expander_pkg.sv
// Shared constants and FSM encoding for the RLE operand expander.
package rle_operand_expander_pkg;

    localparam int unsigned RLE_DATA_W = 16;
    localparam int unsigned RLE_RUN_W  = 8;
    localparam int unsigned RLE_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        VAL  = 2'd2
    } rle_state_e;

endpackage

// File: rtl/rle_stats_counter.sv
// Zero / nonzero output-word statistics counters; clear has priority over increment.
module rle_stats_counter
    import rle_operand_expander_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc_zero,
    input  logic                 inc_nz,
    output logic [RLE_CNT_W-1:0] zero_cnt,
    output logic [RLE_CNT_W-1:0] nz_cnt
);

    // Free-running wrap-around counters with synchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt <= '0;
            nz_cnt   <= '0;
        end else if (clr) begin
            zero_cnt <= '0;
            nz_cnt   <= '0;
        end else begin
            if (inc_zero) zero_cnt <= zero_cnt + RLE_CNT_W'(1);
            if (inc_nz)   nz_cnt   <= nz_cnt + RLE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/rle_operand_expander.sv
// Expands (zero-run, value) tokens into a dense stream of signed operand words.
module rle_operand_expander
    import rle_operand_expander_pkg::*;
#(
    parameter int unsigned DATA_W = RLE_DATA_W,
    parameter int unsigned RUN_W  = RLE_RUN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_value,
    input  logic        [RUN_W-1:0]  in_zrun,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    input  logic                     stats_clr,
    output logic [RLE_CNT_W-1:0]     zero_cnt,
    output logic [RLE_CNT_W-1:0]     nz_cnt
);

    rle_state_e                state;
    logic [RUN_W-1:0]          run_cnt;
    logic signed [DATA_W-1:0]  val_q;
    logic                      last_q;
    logic                      tok_acc;
    logic                      out_hs;

    // A new token is taken when idle, or when the value word drains this cycle.
    assign in_ready = (state == IDLE) || ((state == VAL) && out_ready);
    assign tok_acc  = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Expansion FSM with registered output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            run_cnt   <= '0;
            val_q     <= '0;
            last_q    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (tok_acc) begin
            // Token load: only reachable from IDLE or from VAL while its word drains.
            out_valid <= 1'b1;
            val_q     <= in_value;
            last_q    <= in_last;
            run_cnt   <= in_zrun;
            if (in_zrun != '0) begin
                state    <= ZERO;
                out_data <= '0;
                out_last <= 1'b0;
            end else begin
                state    <= VAL;
                out_data <= in_value;
                out_last <= in_last;
            end
        end else begin
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                end
                ZERO: begin
                    if (out_hs) begin
                        if (run_cnt == RUN_W'(1)) begin
                            state    <= VAL;
                            run_cnt  <= '0;
                            out_data <= val_q;
                            out_last <= last_q;
                        end else begin
                            run_cnt <= run_cnt - RUN_W'(1);
                        end
                    end
                end
                VAL: begin
                    if (out_hs) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // Statistics over every emitted word, classified by its value.
    rle_stats_counter u_stats (
        .clk      (clk),
        .rst      (rst),
        .clr      (stats_clr),
        .inc_zero (out_hs && (out_data == '0)),
        .inc_nz   (out_hs && (out_data != '0)),
        .zero_cnt (zero_cnt),
        .nz_cnt   (nz_cnt)
    );

endmodule

// File: tb/tb_rle_operand_expander.sv
// Scoreboard bench for rle_operand_expander: token table plus directed corner sequences.
module tb_rle_operand_expander;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] in_value = '0;
    logic        [RW-1:0] in_zrun = '0;
    logic                 in_last = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 stats_clr = 1'b0;
    logic [31:0]          zero_cnt;
    logic [31:0]          nz_cnt;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
    } word_t;

    typedef struct {
        int zrun;
        int value;
        bit last;
        int exp_words;
        int exp_zero_words;
    } vec_t;

    word_t       exp_q[$];
    int unsigned hs_cyc_log[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned m_zero = 0;
    int unsigned m_nz = 0;
    bit          prev_stall = 1'b0;
    logic signed [DW-1:0] held_data = '0;
    logic        held_last = 1'b0;
    bit          rand_ready = 1'b0;
    bit          ready_cmd = 1'b0;

    rle_operand_expander dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_zrun   (in_zrun),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .stats_clr (stats_clr),
        .zero_cnt  (zero_cnt),
        .nz_cnt    (nz_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Single owner of out_ready: either a fixed level or a random pattern.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
    end

    // Monitor: handshakes happen at the next rising edge, so inspect here.
    always @(negedge clk) begin
        word_t w;
        bit    have_w;
        cyc++;
        have_w = 1'b0;
        if (rst) begin
            m_zero     = 0;
            m_nz       = 0;
            prev_stall = 1'b0;
        end else begin
            chk("zero_cnt_track", longint'(zero_cnt), longint'(m_zero));
            chk("nz_cnt_track", longint'(nz_cnt), longint'(m_nz));
            if (prev_stall) begin
                chk("hold_valid", longint'(out_valid), 1);
                chk("hold_data", longint'($signed(out_data)), longint'(held_data));
                chk("hold_last", longint'(out_last), longint'(held_last));
            end
            if (out_valid && out_ready) begin
                hs_cyc_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_word: got data %0d last %0d, expected no word",
                             $signed(out_data), out_last);
                end else begin
                    w = exp_q.pop_front();
                    have_w = 1'b1;
                    chk("word_data", longint'($signed(out_data)), longint'(w.data));
                    chk("word_last", longint'(out_last), longint'(w.last));
                end
            end
            if (stats_clr) begin
                m_zero = 0;
                m_nz   = 0;
            end else if (have_w) begin
                if (w.data == '0) m_zero++;
                else              m_nz++;
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end
    end

    // Present one token until accepted, then queue its expected words.
    task automatic send_token(input int zrun, input int value, input bit last);
        bit    acc;
        word_t w;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_zrun  = RW'(zrun);
        in_value = DW'(value);
        in_last  = last;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL token_accept: got no acceptance, expected zrun=%0d value=%0d taken", zrun, value);
        end else begin
            for (int k = 0; k < zrun; k++) begin
                w.data = '0;
                w.last = 1'b0;
                exp_q.push_back(w);
            end
            w.data = DW'(value);
            w.last = last;
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_drain(input int bound, input string name);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < bound) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (exp_q.size() != 0 || out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got %0d words pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic pulse_clr();
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
    endtask

    task automatic chk_burst(input string name, input int h0, input int words);
        if (hs_cyc_log.size() < h0 + words) begin
            chk({name, "_count"}, longint'(hs_cyc_log.size() - h0), longint'(words));
        end else begin
            chk({name, "_span"}, longint'(hs_cyc_log[h0 + words - 1] - hs_cyc_log[h0]),
                longint'(words - 1));
        end
    endtask

    vec_t vecs[7];

    initial begin
        int          h0;
        int unsigned c0;
        int          sum_words;
        int          sum_zero;

        vecs[0] = '{0,    100, 1'b0, 1, 0};
        vecs[1] = '{4,     -3, 1'b0, 5, 4};
        vecs[2] = '{1,      0, 1'b0, 2, 2};
        vecs[3] = '{0,      0, 1'b1, 1, 1};
        vecs[4] = '{7,  32767, 1'b0, 8, 7};
        vecs[5] = '{2, -32768, 1'b1, 3, 2};
        vecs[6] = '{3,     12, 1'b0, 4, 3};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_zero_cnt", longint'(zero_cnt), 0);
        chk("rst_nz_cnt", longint'(nz_cnt), 0);
        rst = 1'b0;
        ready_cmd = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);

        // (3,5,last): latency 1, zeros then value, consecutive
        h0 = hs_cyc_log.size();
        send_token(3, 5, 1'b1);
        c0 = cyc;
        chk("lat_out_valid", longint'(out_valid), 1);
        chk("lat_out_data", longint'($signed(out_data)), 0);
        chk("lat_out_last", longint'(out_last), 0);
        @(negedge clk);
        chk("zero_in_ready", longint'(in_ready), 0);
        wait_drain(20, "drain_035");
        chk_burst("seq035", h0, 4);
        if (hs_cyc_log.size() > h0)
            chk("seq035_first_hs", longint'(hs_cyc_log[h0]), longint'(c0 + 1));

        // Back-to-back tokens with no bubble
        h0 = hs_cyc_log.size();
        send_token(0, -7, 1'b0);
        send_token(0, 9, 1'b0);
        send_token(2, 1, 1'b1);
        wait_drain(20, "drain_036");
        chk("seq036_words", longint'(hs_cyc_log.size() - h0), 5);
        chk_burst("seq036", h0, 5);

        // Backpressure on first zero word
        ready_cmd = 1'b0;
        @(posedge clk);
        #1;
        send_token(2, 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", longint'(in_ready), 0);
            chk("stall_valid", longint'(out_valid), 1);
            chk("stall_data", longint'($signed(out_data)), 0);
        end
        @(posedge clk);
        #1;
        ready_cmd = 1'b1;
        wait_drain(20, "drain_037");

        // Maximum run length
        pulse_clr();
        send_token(255, 1, 1'b1);
        wait_drain(400, "drain_038");
        chk("run255_zero_cnt", longint'(zero_cnt), 255);
        chk("run255_nz_cnt", longint'(nz_cnt), 1);

        // Reset mid-token
        send_token(5, 3, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midrst_pending", longint'(exp_q.size()), 4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_zero_cnt", longint'(zero_cnt), 0);
        chk("midrst_nz_cnt", longint'(nz_cnt), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_idle_valid", longint'(out_valid), 0);
        chk("midrst_idle_in_ready", longint'(in_ready), 1);

        // Clear concurrent with a nonzero handshake
        send_token(0, 6, 1'b0);
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins_nz_cnt", longint'(nz_cnt), 0);
        chk("clr_wins_zero_cnt", longint'(zero_cnt), 0);
        wait_drain(20, "drain_040");

        // Token table under random backpressure
        pulse_clr();
        sum_words = 0;
        sum_zero  = 0;
        rand_ready = 1'b1;
        h0 = hs_cyc_log.size();
        for (int i = 0; i < 7; i++) begin
            send_token(vecs[i].zrun, vecs[i].value, vecs[i].last);
            sum_words += vecs[i].exp_words;
            sum_zero  += vecs[i].exp_zero_words;
        end
        wait_drain(600, "drain_table");
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        chk("table_words", longint'(hs_cyc_log.size() - h0), longint'(sum_words));
        chk("table_zero_cnt", longint'(zero_cnt), longint'(sum_zero));
        chk("table_nz_cnt", longint'(nz_cnt), longint'(sum_words - sum_zero));

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", longint'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
